// File: rtl/mux_pkg.sv
// mux_pkg: shared mode encodings and select-width helper for registered mux/arbiter blocks
package mux_pkg;
  localparam int MUX_MODE_EXT = 0;
  localparam int MUX_MODE_RR = 1;
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick; the first request after `last` wins
module rr_pick #(
  parameter int INPUTS = 4,
  parameter int SEL_W = 2
) (
  input  logic [INPUTS-1:0] req,
  input  logic [SEL_W-1:0]  last,
  output logic [INPUTS-1:0] gnt,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);
  logic [2*INPUTS-1:0] dbl;
  logic [INPUTS-1:0] rot;
  // rot[j] is the request j+1 places after last, wrapping mod INPUTS
  assign dbl = {req, req} >> (int'(last) + 1);
  assign rot = dbl[INPUTS-1:0];
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int j = INPUTS - 1; j >= 0; j--) begin
      if (rot[j]) begin
        any = 1'b1;
        idx = (int'(last) + 1 + j >= INPUTS) ? SEL_W'(int'(last) + 1 + j - INPUTS) : SEL_W'(int'(last) + 1 + j);
      end
    end
    for (int i = 0; i < INPUTS; i++) gnt[i] = any && (idx == SEL_W'(i));
  end
endmodule

// File: rtl/mux_arb_reg.sv
// mux_arb_reg: N-input registered mux with valid/ready flow control,
// selecting by round-robin arbitration or by external select.
module mux_arb_reg import mux_pkg::*; #(
  parameter int WIDTH = 9,
  parameter int INPUTS = 4,
  parameter int SEL_W = sel_width(INPUTS),
  parameter int RR_MODE = MUX_MODE_RR
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [INPUTS-1:0]       in_valid,
  input  logic [INPUTS*WIDTH-1:0] in_data,
  output logic [INPUTS-1:0]       in_ready,
  input  logic [SEL_W-1:0]        ext_sel,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  input  logic                    out_ready
);
  logic [SEL_W-1:0] ptr, rr_idx, src;
  logic [INPUTS-1:0] rr_gnt, ext_gnt;
  logic [WIDTH-1:0] data;
  logic rr_any, load, xfer;
  rr_pick #(.INPUTS(INPUTS), .SEL_W(SEL_W)) u_pick (
    .req(in_valid),
    .last(ptr),
    .gnt(rr_gnt),
    .idx(rr_idx),
    .any(rr_any)
  );
  assign load = !out_valid || out_ready;
  assign src = (RR_MODE == MUX_MODE_RR) ? rr_idx : ext_sel;
  assign in_ready = (reset || !load) ? '0 : (RR_MODE == MUX_MODE_RR) ? (rr_any ? rr_gnt : '0) : ext_gnt;
  assign xfer = |(in_valid & in_ready);
  // an out-of-range ext_sel matches no channel, so nothing is granted
  always_comb begin
    data = '0;
    for (int i = 0; i < INPUTS; i++) begin
      ext_gnt[i] = ext_sel == SEL_W'(i);
      if (src == SEL_W'(i)) data = in_data[i*WIDTH +: WIDTH];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_src <= '0;
      ptr <= SEL_W'(INPUTS - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data <= data;
      out_src <= src;
      if (RR_MODE == MUX_MODE_RR) ptr <= src;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_arb_reg.sv
// tb_mux_arb_reg: checks four configurations (RR/ext x 4/3 inputs) against a behavioural model
module tb_mux_arb_reg;
  import mux_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] v[4];
  logic [63:0] d[4];
  logic [1:0] sel[4];
  logic ordy[4];
  logic [3:0] rdy[4];
  logic ov[4];
  logic [15:0] od[4];
  logic [1:0] os[4];
  int checks = 0;
  int failures = 0;
  int m_ptr[4], m_src[4], m_data[4];
  bit m_val[4];
  int rdy_exp, rdy_seen;

  mux_arb_reg #(.WIDTH(9), .INPUTS(4), .RR_MODE(MUX_MODE_RR)) u_rr4 (
    .clk(clk), .reset(reset), .in_valid(v[0]), .in_data(d[0][35:0]), .in_ready(rdy[0]),
    .ext_sel(sel[0]), .out_valid(ov[0]), .out_data(od[0][8:0]), .out_src(os[0]), .out_ready(ordy[0]));
  mux_arb_reg #(.WIDTH(9), .INPUTS(4), .RR_MODE(MUX_MODE_EXT)) u_ext4 (
    .clk(clk), .reset(reset), .in_valid(v[1]), .in_data(d[1][35:0]), .in_ready(rdy[1]),
    .ext_sel(sel[1]), .out_valid(ov[1]), .out_data(od[1][8:0]), .out_src(os[1]), .out_ready(ordy[1]));
  mux_arb_reg #(.WIDTH(16), .INPUTS(3), .RR_MODE(MUX_MODE_RR)) u_rr3 (
    .clk(clk), .reset(reset), .in_valid(v[2][2:0]), .in_data(d[2][47:0]), .in_ready(rdy[2][2:0]),
    .ext_sel(sel[2]), .out_valid(ov[2]), .out_data(od[2]), .out_src(os[2]), .out_ready(ordy[2]));
  mux_arb_reg #(.WIDTH(9), .INPUTS(3), .RR_MODE(MUX_MODE_EXT)) u_ext3 (
    .clk(clk), .reset(reset), .in_valid(v[3][2:0]), .in_data(d[3][26:0]), .in_ready(rdy[3][2:0]),
    .ext_sel(sel[3]), .out_valid(ov[3]), .out_data(od[3][8:0]), .out_src(os[3]), .out_ready(ordy[3]));

  function automatic int nn(input int id);
    return id < 2 ? 4 : 3;
  endfunction
  function automatic int ww(input int id);
    return id == 2 ? 16 : 9;
  endfunction
  function automatic bit is_rr(input int id);
    return id % 2 == 0;
  endfunction

  // channel granted this cycle (-1 for none), from the arbitration rules
  function automatic int exp_g(input int id, input logic [3:0] vv, input logic [1:0] ss, input logic r);
    int n = nn(id);
    if (reset || !(!m_val[id] || r)) return -1;
    if (!is_rr(id)) return (int'(ss) < n) ? int'(ss) : -1;
    for (int k = 1; k <= n; k++)
      if (((vv >> ((m_ptr[id] + k) % n)) & 4'd1) != 4'd0) return (m_ptr[id] + k) % n;
    return -1;
  endfunction

  function automatic void model_edge(input int id, input logic [3:0] vv, input logic [63:0] dd, input logic r, input int g);
    if (reset) begin
      m_val[id] = 1'b0; m_data[id] = 0; m_src[id] = 0; m_ptr[id] = nn(id) - 1;
    end else if (g >= 0 && ((vv >> g) & 4'd1) != 4'd0) begin
      m_val[id] = 1'b1;
      m_data[id] = int'((dd >> (g * ww(id))) & ((64'd1 << ww(id)) - 64'd1));
      m_src[id] = g;
      if (is_rr(id)) m_ptr[id] = g;
    end else if (r) begin
      m_val[id] = 1'b0;
    end
  endfunction

  task automatic step(input int id, input logic [3:0] vv, input logic [63:0] dd, input logic [1:0] ss, input logic r, input logic rs);
    int g;
    @(negedge clk);
    reset = rs; v[id] = vv; d[id] = dd; sel[id] = ss; ordy[id] = r;
    g = exp_g(id, vv, ss, r);
    rdy_exp = g >= 0 ? (1 << g) : 0;
    #1 rdy_seen = int'(rdy[id] & 4'((1 << nn(id)) - 1));
    @(posedge clk);
    model_edge(id, vv, dd, r, g);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      step(0, 4'hF, {$urandom(), $urandom()}, 2'd0, 1'b1, 1'b1);
      checks++;
      if (rdy_seen !== 0) begin failures++; $display("FAIL reset_ready: in_ready=%0h required 0", rdy_seen); end
      checks++;
      if (ov[0] !== 1'b0 || od[0][8:0] !== 9'd0 || os[0] !== 2'd0) begin
        failures++; $display("FAIL reset_out: valid=%b data=%0h src=%0d required 0/0/0", ov[0], od[0][8:0], os[0]);
      end
    end
    step(0, 4'hF, 64'h0, 2'd0, 1'b1, 1'b0);
    checks++;
    if (rdy_seen !== 1) begin failures++; $display("FAIL reset_first_grant: in_ready=%0h required 1", rdy_seen); end
    checks++;
    if (ov[0] !== 1'b1 || os[0] !== 2'd0) begin failures++; $display("FAIL reset_first_out: valid=%b src=%0d required 1/0", ov[0], os[0]); end
  endtask

  task automatic test_fairness();
    logic [63:0] dd = '0;
    for (int i = 0; i < 4; i++) dd |= (64'h100 + 64'(i)) << (9 * i);
    step(0, 4'h0, 64'h0, 2'd0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(0, 4'hF, dd, 2'd0, 1'b1, 1'b0);
      checks++;
      if (rdy_seen !== rdy_exp || rdy_seen !== (1 << (k % 4))) begin
        failures++; $display("FAIL fair_ready[%0d]: in_ready=%0h required %0h", k, rdy_seen, rdy_exp);
      end
      checks++;
      if (ov[0] !== 1'b1 || int'(os[0]) !== k % 4 || int'(od[0][8:0]) !== 'h100 + k % 4 || int'(od[0][8:0]) !== m_data[0]) begin
        failures++; $display("FAIL fair_out[%0d]: src=%0d data=%0h required %0d/%0h", k, os[0], od[0][8:0], k % 4, 'h100 + k % 4);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] dd = {28'h0, 9'h1F3, 9'h0AB, 9'h1F1, 9'h1F0};
    step(0, 4'h0, 64'h0, 2'd0, 1'b1, 1'b1);
    step(0, 4'b0100, dd, 2'd0, 1'b1, 1'b0);
    checks++;
    if (ov[0] !== 1'b1 || od[0][8:0] !== 9'h0AB || os[0] !== 2'd2) begin
      failures++; $display("FAIL bp_load: data=%0h src=%0d required 0ab/2", od[0][8:0], os[0]);
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 4'hF, dd, 2'd0, 1'b0, 1'b0);
      checks++;
      if (rdy_seen !== 0) begin failures++; $display("FAIL bp_ready[%0d]: in_ready=%0h required 0", k, rdy_seen); end
      checks++;
      if (ov[0] !== 1'b1 || od[0][8:0] !== 9'h0AB || os[0] !== 2'd2) begin
        failures++; $display("FAIL bp_hold[%0d]: valid=%b data=%0h src=%0d required 1/0ab/2", k, ov[0], od[0][8:0], os[0]);
      end
    end
    step(0, 4'hF, dd, 2'd0, 1'b1, 1'b0);
    checks++;
    if (rdy_seen !== 8 || rdy_seen !== rdy_exp) begin failures++; $display("FAIL bp_release: in_ready=%0h required 8", rdy_seen); end
    checks++;
    if (os[0] !== 2'd3 || od[0][8:0] !== 9'h1F3) begin failures++; $display("FAIL bp_next: src=%0d data=%0h required 3/1f3", os[0], od[0][8:0]); end
  endtask

  task automatic test_sparse();
    int seq[3] = '{1, 3, 1};
    step(0, 4'h0, 64'h0, 2'd0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(0, 4'b1010, {$urandom(), $urandom()}, 2'd0, 1'b1, 1'b0);
      checks++;
      if (rdy_seen !== (1 << seq[k])) begin failures++; $display("FAIL sparse_ready[%0d]: in_ready=%0h required %0h", k, rdy_seen, 1 << seq[k]); end
      checks++;
      if (int'(os[0]) !== seq[k] || int'(od[0][8:0]) !== m_data[0]) begin
        failures++; $display("FAIL sparse_out[%0d]: src=%0d data=%0h required %0d/%0h", k, os[0], od[0][8:0], seq[k], m_data[0]);
      end
    end
  endtask

  task automatic test_ext();
    step(1, 4'h0, 64'h0, 2'd0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1, 4'hF, {$urandom(), $urandom()}, 2'd2, 1'b1, 1'b0);
      checks++;
      if (rdy_seen !== 4) begin failures++; $display("FAIL ext_ready[%0d]: in_ready=%0h required 4", k, rdy_seen); end
      checks++;
      if (ov[1] !== 1'b1 || os[1] !== 2'd2 || int'(od[1][8:0]) !== m_data[1]) begin
        failures++; $display("FAIL ext_out[%0d]: valid=%b src=%0d data=%0h required 1/2/%0h", k, ov[1], os[1], od[1][8:0], m_data[1]);
      end
    end
    step(1, 4'b1011, {$urandom(), $urandom()}, 2'd2, 1'b1, 1'b0);
    checks++;
    if (rdy_seen !== 4) begin failures++; $display("FAIL ext_idle_ready: in_ready=%0h required 4", rdy_seen); end
    checks++;
    if (ov[1] !== 1'b0) begin failures++; $display("FAIL ext_drain: valid=%b required 0", ov[1]); end
    step(3, 4'h0, 64'h0, 2'd0, 1'b1, 1'b1);
    step(3, 4'hF, {$urandom(), $urandom()}, 2'd3, 1'b1, 1'b0);
    checks++;
    if (rdy_seen !== 0 || ov[3] !== 1'b0) begin failures++; $display("FAIL ext_range: in_ready=%0h valid=%b required 0/0", rdy_seen, ov[3]); end
  endtask

  task automatic test_odd();
    step(2, 4'h0, 64'h0, 2'd0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(2, 4'h7, {$urandom(), $urandom()}, 2'd0, 1'b1, 1'b0);
      checks++;
      if (int'(os[2]) !== k % 3 || int'(od[2]) !== m_data[2] || ov[2] !== 1'b1) begin
        failures++; $display("FAIL odd_out[%0d]: src=%0d data=%0h required %0d/%0h", k, os[2], od[2], k % 3, m_data[2]);
      end
      checks++;
      if (u_rr3.ptr === 2'd3) begin failures++; $display("FAIL odd_ptr[%0d]: ptr=%0d required <3", k, u_rr3.ptr); end
    end
  endtask

  task automatic test_random(input int id);
    step(id, 4'h0, 64'h0, 2'd0, 1'b1, 1'b1);
    for (int k = 0; k < 40; k++) begin
      step(id, 4'($urandom()), {$urandom(), $urandom()}, 2'($urandom()), $urandom_range(0, 3) != 0, 1'b0);
      checks++;
      if (rdy_seen !== rdy_exp) begin failures++; $display("FAIL rand%0d_ready[%0d]: in_ready=%0h required %0h", id, k, rdy_seen, rdy_exp); end
      checks++;
      if (ov[id] !== m_val[id] || (int'(od[id]) & ((1 << ww(id)) - 1)) !== m_data[id] || int'(os[id]) !== m_src[id]) begin
        failures++;
        $display("FAIL rand%0d_out[%0d]: valid=%b data=%0h src=%0d required %b/%0h/%0d", id, k, ov[id],
                 int'(od[id]) & ((1 << ww(id)) - 1), os[id], m_val[id], m_data[id], m_src[id]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      v[i] = '0; d[i] = '0; sel[i] = '0; ordy[i] = 1'b1;
    end
    test_reset();
    test_fairness();
    test_backpressure();
    test_sparse();
    test_ext();
    test_odd();
    for (int i = 0; i < 4; i++) test_random(i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
